// File: rtl/systolic_seq.sv
// Sequencer for an NxN weight-stationary systolic array: weight load, switch, input stream, drain.
// Define SYSTOLIC_SEQ_PERF_CNT_EN to build in the busy-cycle counter behind cycle_count.
module systolic_seq #(
  parameter  int N     = 4,
  parameter  int VEC_W = 8,
  localparam int AW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [VEC_W-1:0] num_vectors,
  input  logic             in_ready,
  output logic [AW-1:0]    w_rd_addr,
  output logic             w_accept,
  output logic             sw_pulse,
  output logic [VEC_W-1:0] in_rd_addr,
  output logic             in_valid,
  output logic             pe_enabled,
  output logic             busy,
  output logic             done,
  output logic [31:0]      cycle_count
);

  localparam int DW = $clog2(2*N) + 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, SWITCH, STREAM, DRAIN, DONE} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_w_addr;
  logic             r_w_acc;
  logic             r_sw;
  logic [VEC_W-1:0] r_in_addr;
  logic             r_in_vld;
  logic             r_busy;
  logic             r_done;
  logic [VEC_W-1:0] r_nv;
  logic [VEC_W-1:0] r_cnt;
  logic [DW-1:0]    r_dcnt;

  // Outputs are computed for the state being entered, so in_ready is sampled
  // at the edge that opens the cycle it qualifies.
  always_ff @(posedge clk) begin
    if (!rst || (r_state != IDLE && abort)) begin
      r_state   <= IDLE;
      r_w_addr  <= '0;
      r_w_acc   <= 1'b0;
      r_sw      <= 1'b0;
      r_in_addr <= '0;
      r_in_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_nv      <= '0;
      r_cnt     <= '0;
      r_dcnt    <= '0;
    end else begin
      r_w_acc  <= 1'b0;
      r_sw     <= 1'b0;
      r_in_vld <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state   <= LOAD_W;
          r_nv      <= num_vectors;
          r_w_acc   <= 1'b1;
          r_w_addr  <= '0;
          r_in_addr <= '0;
          r_cnt     <= '0;
          r_busy    <= 1'b1;
        end
        LOAD_W: if (r_w_addr == AW'(N-1)) begin
          r_state  <= SWITCH;
          r_sw     <= 1'b1;
          r_w_addr <= '0;
        end else begin
          r_w_acc  <= 1'b1;
          r_w_addr <= r_w_addr + 1'b1;
        end
        SWITCH: if (r_nv == '0) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end else begin
          r_state <= STREAM;
          if (in_ready) begin
            r_in_vld  <= 1'b1;
            r_in_addr <= r_cnt;
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        STREAM: if (r_cnt == r_nv) begin
          r_state <= DRAIN;
          r_dcnt  <= '0;
        end else if (in_ready) begin
          r_in_vld  <= 1'b1;
          r_in_addr <= r_cnt;
          r_cnt     <= r_cnt + 1'b1;
        end
        DRAIN: if (r_dcnt == DW'(2*N-1)) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
        DONE: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_in_addr <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic [31:0] r_cyc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cyc <= '0;
    end else if (r_state == IDLE) begin
      if (start) r_cyc <= '0;
    end else if (abort) begin
      r_cyc <= '0;
    end else if (r_cyc != '1) begin
      r_cyc <= r_cyc + 32'd1;
    end
  end

  assign cycle_count = r_cyc;
`else
  assign cycle_count = '0;
`endif

  assign w_rd_addr  = r_w_addr;
  assign w_accept   = r_w_acc;
  assign sw_pulse   = r_sw;
  assign in_rd_addr = r_in_addr;
  assign in_valid   = r_in_vld;
  assign busy       = r_busy;
  assign pe_enabled = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq: table jobs, random jobs against a timeline model, and abort/reset/held-start cases.
module tb_systolic_seq;

  localparam int N     = 4;
  localparam int VEC_W = 8;
  localparam int AW    = $clog2(N);
  localparam int MAXC  = 600;
  localparam int OW    = AW + VEC_W + 38;
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef logic [OW-1:0] obs_t;
  typedef struct {int nv; int stall; int exp_done;} vec_t;

  logic             clk = 1'b0;
  logic             rst, start, abort, in_ready;
  logic [VEC_W-1:0] num_vectors;
  logic [AW-1:0]    w_rd_addr;
  logic             w_accept, sw_pulse, in_valid, pe_enabled, busy, done;
  logic [VEC_W-1:0] in_rd_addr;
  logic [31:0]      cycle_count;
  obs_t             w_obs;

  int checks = 0;
  int errors = 0;
  bit rdy [0:MAXC-1];
  vec_t tab [6];

  systolic_seq #(.N(N), .VEC_W(VEC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vectors(num_vectors),
    .in_ready(in_ready), .w_rd_addr(w_rd_addr), .w_accept(w_accept), .sw_pulse(sw_pulse),
    .in_rd_addr(in_rd_addr), .in_valid(in_valid), .pe_enabled(pe_enabled), .busy(busy),
    .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  assign w_obs = {w_accept, w_rd_addr, sw_pulse, in_valid, in_rd_addr, busy, pe_enabled, done, cycle_count};

  function automatic obs_t pack(bit wa, int wad, bit sw, bit iv, int ia, bit b, bit d, int cc);
    return {wa, AW'(wad), sw, iv, VEC_W'(ia), b, b, d, 32'(cc)};
  endfunction

  task automatic check(input string name, input int cy, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got=%h exp=%h", name, cy, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rdy[c] is the in_ready value presented for cycle c (driven during cycle c-1).
  // The job timeline is derived from issue cycles: load N, switch 1, stream, drain 2N, done 1.
  task automatic run_job(input int nv, input int abort_at, input bit hold, output int done_seen);
    int   iss[$];
    int   c, k, done_c, last, ia;
    bit   iv;
    obs_t e;
    c = N + 2;
    k = 0;
    while (k < nv && c < MAXC - 4) begin
      if (rdy[c]) begin iss.push_back(c); k++; end
      c++;
    end
    done_c = (nv == 0) ? N + 2 : iss[$] + 2*N + 1;
    last   = (abort_at > 0) ? abort_at + 1 : done_c + (hold ? 2 : 1);
    done_seen   = -1;
    num_vectors = VEC_W'(nv);
    start       = 1'b1;
    in_ready    = rdy[1];
    for (int cy = 1; cy <= last; cy++) begin
      tick();
      if (done === 1'b1 && done_seen < 0) done_seen = cy;
      if (abort_at > 0 && cy == abort_at + 1)
        e = '0;
      else if (cy == done_c + 1)
        e = pack(0, 0, 0, 0, 0, 0, 0, PERF ? done_c : 0);
      else if (cy == done_c + 2)
        e = pack(1, 0, 0, 0, 0, 1, 0, 0);
      else begin
        iv = 1'b0;
        ia = 0;
        foreach (iss[i]) begin
          if (iss[i] == cy) iv = 1'b1;
          if (iss[i] <= cy) ia = i;
        end
        e = pack(cy <= N, (cy <= N) ? cy - 1 : 0, cy == N + 1, iv, ia, 1'b1, cy == done_c,
                 PERF ? cy - 1 : 0);
      end
      check("job_cycle", cy, w_obs, e);
      if (!hold) start = 1'b0;
      abort    = (cy == abort_at);
      in_ready = rdy[cy + 1];
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int ds;
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_ready = 1'b0; num_vectors = '0;
    repeat (3) tick();
    check("reset", 0, w_obs, '0);
    rst = 1'b1;
    tick();
    check("idle_after_reset", 0, w_obs, '0);

    tab[0] = '{3, 0, 17};
    tab[1] = '{3, 7, 18};
    tab[2] = '{0, 0, 6};
    tab[3] = '{1, 0, 15};
    tab[4] = '{5, 0, 19};
    tab[5] = '{2, 6, 17};
    foreach (tab[t]) begin
      foreach (rdy[i]) rdy[i] = 1'b1;
      if (tab[t].stall > 0) rdy[tab[t].stall] = 1'b0;
      run_job(tab[t].nv, 0, 1'b0, ds);
      check_int("table_done_cycle", ds, tab[t].exp_done);
    end

    for (int j = 0; j < 8; j++) begin
      foreach (rdy[i]) rdy[i] = ($urandom_range(0, 3) != 0);
      run_job(int'($urandom_range(0, 12)), 0, 1'b0, ds);
    end

    foreach (rdy[i]) rdy[i] = 1'b1;
    run_job(255, 0, 1'b0, ds);
    check_int("max_vectors_done_cycle", ds, 269);

    run_job(3, 7, 1'b0, ds);
    check_int("abort_no_done", ds, -1);
    run_job(3, 0, 1'b0, ds);
    check_int("restart_after_abort", ds, 17);

    run_job(3, 0, 1'b1, ds);
    check_int("held_start_done", ds, 17);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("held_start_abort", 0, w_obs, '0);

    num_vectors = 8'd3;
    start = 1'b1;
    tick();
    check("rst_job_cycle1", 1, w_obs, pack(1, 0, 0, 0, 0, 1, 0, 0));
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid_load", 3, w_obs, '0);
    rst = 1'b1;
    for (int cy = 4; cy < 24; cy++) begin
      tick();
      check("rst_stays_idle", cy, w_obs, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
